fft4_frame_loader: RTL and testbench

//  Input stage of the 4-point FFT datapath. Collects serial complex samples over a

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft4_bank.sv | 34 +++
 rtl/fft4_frame_loader.sv | 73 +++++++
 tb/tb_fft4_frame_loader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared sample geometry and index helpers for the 4-point FFT datapath.
package fft_pkg;
  localparam int DW = 16;
  localparam int N_PTS = 4;
  localparam int RE_MSB = DW - 1;
  localparam int RE_LSB = DW / 2;
  localparam int IM_MSB = DW / 2 - 1;
  localparam int IM_LSB = 0;
  typedef logic [DW-1:0] sample_t;
  function automatic logic [1:0] brev2(input logic [1:0] idx);
    return {idx[0], idx[1]};
  endfunction
endpackage

// File: rtl/fft4_bank.sv
// fft4_bank: one 4-slot frame buffer with indexed write, zero-fill of the tail
// on early close, and a full flag set on close / cleared on consume.
module fft4_bank
  import fft_pkg::*;
#(
  parameter int W = DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [1:0]              i_idx,
  input  logic [W-1:0]            i_data,
  input  logic                    i_zfill,
  input  logic                    i_close,
  input  logic                    i_clr,
  output logic [N_PTS-1:0][W-1:0] o_x,
  output logic                    o_full
);
  logic [N_PTS-1:0][W-1:0] r_x;
  logic                    r_full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_full <= 1'b0;
    end else begin
      for (int j = 0; j < N_PTS; j++)
        if (i_we && j == int'(i_idx)) r_x[j] <= i_data;
        else if (i_zfill && j > int'(i_idx)) r_x[j] <= '0;
      r_full <= i_clr ? 1'b0 : (i_close ? 1'b1 : r_full);
    end
  end
  assign o_x    = r_x;
  assign o_full = r_full;
endmodule

// File: rtl/fft4_frame_loader.sv
// fft4_frame_loader: gathers serial complex samples into ping-pong 4-sample
// frames and presents each frame in parallel (optionally bit-reversed).
module fft4_frame_loader
  import fft_pkg::*;
#(
  parameter int DW     = fft_pkg::DW,
  parameter bit BITREV = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] o0,
  output logic [DW-1:0] o1,
  output logic [DW-1:0] o2,
  output logic [DW-1:0] o3,
  output logic          frame_err
);
  logic                              r_wr_bank, r_rd_bank, r_err;
  logic [1:0]                        r_wr_idx;
  logic [1:0]                        w_full;
  logic [1:0][N_PTS-1:0][DW-1:0]     w_x;
  logic [N_PTS-1:0][DW-1:0]          w_o;
  logic                              w_acc, w_close, w_cons;
  assign s_ready = !w_full[r_wr_bank];
  assign m_valid = w_full[r_rd_bank];
  assign w_acc   = s_valid && s_ready;
  assign w_close = w_acc && (s_last || r_wr_idx == 2'd3);
  assign w_cons  = m_valid && m_ready;
  // A bank is never written while full and never consumed while empty, so
  // close and consume can never hit the same bank in one cycle.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft4_bank #(.W(DW)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_acc && r_wr_bank == 1'(b)),
      .i_idx   (r_wr_idx),
      .i_data  (s_data),
      .i_zfill (w_close && s_last && r_wr_bank == 1'(b)),
      .i_close (w_close && r_wr_bank == 1'(b)),
      .i_clr   (w_cons && r_rd_bank == 1'(b)),
      .o_x     (w_x[b]),
      .o_full  (w_full[b])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_acc) r_wr_idx <= w_close ? 2'd0 : r_wr_idx + 2'd1;
      if (w_close) r_wr_bank <= !r_wr_bank;
      if (w_cons) r_rd_bank <= !r_rd_bank;
      r_err <= w_close && s_last && r_wr_idx != 2'd3;
    end
  end
  always_comb begin
    w_o = '0;
    for (int k = 0; k < N_PTS; k++)
      w_o[k] = m_valid ? w_x[r_rd_bank][BITREV ? brev2(2'(k)) : 2'(k)] : '0;
  end
  assign o0        = w_o[0];
  assign o1        = w_o[1];
  assign o2        = w_o[2];
  assign o3        = w_o[3];
  assign frame_err = r_err;
endmodule

// File: tb/tb_fft4_frame_loader.sv
// tb_fft4_frame_loader: scoreboard bench; a bit-reversed and a natural-order
// loader share one input stream and are checked frame by frame.
module tb_fft4_frame_loader;
  logic        clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, m_valid, frame_err;
  logic [15:0] o0, o1, o2, o3;
  logic        n_s_ready, n_m_valid, n_frame_err;
  logic [15:0] n_o0, n_o1, n_o2, n_o3;
  typedef logic [3:0][15:0] frame_t;
  frame_t exp_q[$];
  frame_t mon_e;
  int n_tests = 0, n_fail = 0, cyc = 0, errcnt = 0, stalls = 0;

  fft4_frame_loader #(.DW(16), .BITREV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .frame_err(frame_err)
  );
  fft4_frame_loader #(.DW(16), .BITREV(1'b0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(n_s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(n_m_valid), .m_ready(m_ready),
    .o0(n_o0), .o1(n_o1), .o2(n_o2), .o3(n_o3), .frame_err(n_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic frame_t mk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    logic rdy;
    s_valid = 1'b1; s_data = d; s_last = l;
    do begin
      @(negedge clk); rdy = s_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 0, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  always @(negedge clk) begin
    if (frame_err) errcnt++;
    if (s_valid && !s_ready) stalls++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("brev_o0", o0, mon_e[0]);
        chk("brev_o1", o1, mon_e[2]);
        chk("brev_o2", o2, mon_e[1]);
        chk("brev_o3", o3, mon_e[3]);
        chk("nat_m_valid", n_m_valid, 1);
        chk("nat_o0", n_o0, mon_e[0]);
        chk("nat_o1", n_o1, mon_e[1]);
        chk("nat_o2", n_o2, mon_e[2]);
        chk("nat_o3", n_o3, mon_e[3]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t0, n;
    // reset state
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_o0", o0, 0); chk("rst_o1", o1, 0); chk("rst_o2", o2, 0); chk("rst_o3", o3, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // 1: basic frame, latency
    m_ready = 1'b1;
    exp_q.push_back(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
    send(16'h0100, 0); send(16'h0200, 0); send(16'h0300, 0);
    chk("t1_m_valid_before", m_valid, 0);
    send(16'h0400, 0);
    chk("t1_m_valid_latency", m_valid, 1);
    chk("t1_s_ready", s_ready, 1);
    @(posedge clk); #1;
    // 2: backpressure, two frames held, ninth waits
    m_ready = 1'b0;
    exp_q.push_back(mk(16'h1001, 16'h1002, 16'h1003, 16'h1004));
    exp_q.push_back(mk(16'h2001, 16'h2002, 16'h2003, 16'h2004));
    for (int i = 1; i <= 4; i++) send(16'h1000 + 16'(i), 0);
    for (int i = 1; i <= 4; i++) send(16'h2000 + 16'(i), 0);
    chk("t2_s_ready_full", s_ready, 0);
    chk("t2_m_valid_held", m_valid, 1);
    chk("t2_o0_held", o0, 16'h1001);
    exp_q.push_back(mk(16'h3001, 16'h3002, 16'h3003, 16'h3004));
    fork
      send(16'h3001, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t2_s_ready_still_low", s_ready, 0);
        m_ready = 1'b1;
      end
    join
    send(16'h3002, 0); send(16'h3003, 0); send(16'h3004, 0);
    repeat (2) @(posedge clk); #1;
    // 3: early close
    errcnt = 0;
    exp_q.push_back(mk(16'h0A0B, 16'h0C0D, 16'h0000, 16'h0000));
    send(16'h0A0B, 0); send(16'h0C0D, 1);
    chk("t3_frame_err_pulse", frame_err, 1);
    chk("t3_m_valid", m_valid, 1);
    @(posedge clk); #1;
    chk("t3_frame_err_clear", frame_err, 0);
    chk("t3_err_count", errcnt, 1);
    repeat (2) @(posedge clk); #1;
    // 4: continuous stream, last frame closed by s_last at idx 3
    errcnt = 0; stalls = 0;
    for (int f = 0; f < 3; f++)
      exp_q.push_back(mk(16'h4000 + 16'(4*f), 16'h4001 + 16'(4*f),
                         16'h4002 + 16'(4*f), 16'h4003 + 16'(4*f)));
    t0 = cyc;
    for (int i = 0; i < 12; i++) send(16'h4000 + 16'(i), i == 11);
    chk("t4_cycles", cyc - t0, 12);
    repeat (2) @(posedge clk); #1;
    chk("t4_stalls", stalls, 0);
    chk("t4_no_err", errcnt, 0);
    chk("t4_drained", exp_q.size(), 0);
    // 5: reset with a held frame and a partial frame
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h5000 + 16'(i), 0);
    send(16'h6001, 0); send(16'h6002, 0);
    chk("t5_m_valid_pre", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_s_ready", s_ready, 1);
    chk("t5_o0", o0, 0); chk("t5_o1", o1, 0); chk("t5_o2", o2, 0); chk("t5_o3", o3, 0);
    chk("t5_nat_o0", n_o0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready = 1'b1;
    exp_q.push_back(mk(16'h7001, 16'h7002, 16'h7003, 16'h7004));
    for (int i = 1; i <= 4; i++) send(16'h7000 + 16'(i), 0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_m_valid", m_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
